nanorv32_muldiv_seq: RTL
========================

# nanorv32_muldiv_seq

Parametrised, iterative RV32M multiply/divide unit with a valid/ready request and response handshake. It is the multi-cycle successor to the combinational ALU multiply path and the existing radix-2 divider. It is a single engine: a configurable-radix shift-add multiplier and a restoring divider share one accumulator and one sign-fixup stage. It sits beside the ALU in the execute stage, and the core stalls on `req_ready`/`resp_valid`.

## Interface
- `DATA_W`, 32: operand and result width; even, ≥ 8.
- `MUL_UNROLL`, 1: multiplier bits retired per cycle; power of 2 dividing `DATA_W`. `DATA_W` gives single-iteration multiply.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high. This is the one clock and reset of the block.
- `flush`  in  1  abort the operation in flight; no response is produced.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_op`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `req_a`, `req_b`  in  `DATA_W`  operands rs1 and rs2; captured at accept.
- `resp_valid`  out  1  result available; held until taken.
- `resp_ready`  in  1  consumer takes the result.
- `resp_result`  out  `DATA_W`  result; registered, stable while `resp_valid`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **States:**
  - IDLE: on accept (`req_valid & req_ready`), latch the op and operand magnitudes, plus the negate flag (`neg = sign_a ^ sign_b` for mul and quotient, `sign_a` for remainder). Go to CALC, or to DONE for a special case.
  - CALC: run the iteration counter from N-1 down to 0. Multiply uses N = `DATA_W`/`MUL_UNROLL`; divide uses N = `DATA_W`. At 0, go to FIX.
  - FIX: conditional two's-complement negate of the 2·`DATA_W` product or of the quotient/remainder. Select the result word, then go to DONE.
  - DONE: `resp_valid`=1. On `resp_ready`, go to IDLE.
- **Signedness:**
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: both signed.
  - MUL, MULHU, DIVU, REMU: unsigned.
  - Magnitudes are taken at accept. The full 2·`DATA_W` product is formed.
  - MUL returns `[DATA_W-1:0]`; MULH* return `[2·DATA_W-1:DATA_W]`.
- **Multiplier:** each CALC cycle adds `MUL_UNROLL` partial products of b into the upper accumulator, then shifts the accumulator right by `MUL_UNROLL`.
- **Divider:** restoring, one quotient bit per cycle. The remainder register is `DATA_W`+1 bits.
- **Special cases** skip CALC/FIX: accept → DONE next cycle.
  - Divisor 0: quotient = all ones; remainder = a.
  - Signed overflow (a = −2^(`DATA_W`-1), b = −1): quotient = a; remainder = 0.
- **`flush`:** in any state, go to IDLE next cycle and clear `resp_valid`; the result is discarded. `flush` with `req_valid` in IDLE suppresses the accept.
- **`rst`:** highest priority, including mid-operation.
  - After reset: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_result`=0, `busy`=0, counters and accumulators 0.
- `req_op`, `req_a` and `req_b` are don't-care after accept.

## Timing
- Accept in cycle 0. `resp_valid` rises in cycle N+2: N CALC cycles, then 1 FIX cycle.
  - `DATA_W`=32, `MUL_UNROLL`=1: 34 cycles for both mul and div.
  - `MUL_UNROLL`=32: multiply takes 3 cycles.
- Special-case divide: `resp_valid` in cycle 1.
- `resp_valid`, `resp_result` and `req_ready` are registered or decoded from state only. There is no combinational path from `req_*` to `resp_*`.
- No back-to-back overlap: the earliest next accept is the cycle after the `resp_valid & resp_ready` handshake.
- `resp_valid` does not drop without a handshake, except on `flush` or `rst`.

## Structure
- Add to the shared `nanorv32_parameters.v` include:
  - funct3 op encodings `NANORV32_MULDIV_OP_*`;
  - state encodings `NANORV32_MULDIV_ST_{IDLE,CALC,FIX,DONE}`;
  - `DATA_W` default.
- One sub-module, `nanorv32_muldiv_absneg`: parametrised-width conditional two's-complement negate (`in`, `neg`, `out`). It is instantiated for the a and b magnitudes at accept, and at `2·DATA_W` in FIX.
- The control FSM, counter and datapath stay in the top module. The legacy combinational multiplier stays in the ALU until the core switches over.

## Test plan
1. MULH, MULHU, MULHSU with a = b = 0xFFFFFFFF:
   - MULH → 0x00000000; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
   - MUL → 0x00000001.
   - All arrive at cycle 34. Repeat with `MUL_UNROLL`=32: cycle 3.
2. DIV −7 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2. Each takes 34 cycles.
3. Divide by zero and overflow, each with `resp_valid` at cycle 1:
   - DIVU 7 / 0 → 0xFFFFFFFF; REMU 7 / 0 → 7.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
4. Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid`.
   - `resp_valid` and `resp_result` stay stable and `req_ready`=0 throughout.
   - Handshake → IDLE; the next request is accepted one cycle later.
5. `flush` and `rst` mid-operation:
   - `flush` at CALC cycle 10 → no `resp_valid`; `req_ready`=1 the next cycle.
   - `rst` at CALC cycle 20 → all outputs at reset values.
   - A following MUL 3 × 5 → 15.
6. Operands changed after accept: `req_a` and `req_b` randomised every cycle during CALC. The result matches the captured operands, checked against a 1000-vector random reference model across all eight ops.

Source files
------------

// File: rtl/nanorv32_muldiv_seq_pkg.sv
// nanorv32_muldiv_seq_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - default data width
//   - RV32M funct3 op encodings
//   - control FSM state encoding
//   - request decode helper (signedness / class of an op)
package nanorv32_muldiv_seq_pkg;

    localparam int NANORV32_DATA_W = 32;

    // RV32M funct3 encodings
    localparam logic [2:0] NANORV32_MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] NANORV32_MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] NANORV32_MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] NANORV32_MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] NANORV32_MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] NANORV32_MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] NANORV32_MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] NANORV32_MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        NANORV32_MULDIV_ST_IDLE = 2'd0,
        NANORV32_MULDIV_ST_CALC = 2'd1,
        NANORV32_MULDIV_ST_FIX  = 2'd2,
        NANORV32_MULDIV_ST_DONE = 2'd3
    } muldiv_state_t;

    typedef struct packed {
        logic is_mul;    // multiply class (funct3[2] == 0)
        logic is_rem;    // REM / REMU
        logic a_signed;  // rs1 treated as signed
        logic b_signed;  // rs2 treated as signed
    } muldiv_dec_t;

    function automatic muldiv_dec_t muldiv_decode(input logic [2:0] op);
        muldiv_dec_t d;
        d.is_mul   = ~op[2];
        d.is_rem   = op[2] & op[1];
        d.a_signed = (op == NANORV32_MULDIV_OP_MULH)   ||
                     (op == NANORV32_MULDIV_OP_MULHSU) ||
                     (op == NANORV32_MULDIV_OP_DIV)    ||
                     (op == NANORV32_MULDIV_OP_REM);
        d.b_signed = (op == NANORV32_MULDIV_OP_MULH)   ||
                     (op == NANORV32_MULDIV_OP_DIV)    ||
                     (op == NANORV32_MULDIV_OP_REM);
        return d;
    endfunction

endpackage

// File: rtl/nanorv32_muldiv_absneg.sv
// nanorv32_muldiv_absneg
// Conditional two's-complement negate of a WIDTH-bit word. Used to take
// operand magnitudes at accept and to restore the result sign in FIX.
// Ports:
//   in   [WIDTH-1:0]  value
//   neg               1: output -in, 0: output in
//   out  [WIDTH-1:0]  result
module nanorv32_muldiv_absneg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);

    assign out = neg ? (~in + 1'b1) : in;

endmodule

// File: rtl/nanorv32_muldiv_seq.sv
// nanorv32_muldiv_seq
// Iterative RV32M multiply/divide unit. One shared accumulator serves a
// MUL_UNROLL-bits-per-cycle shift-add multiplier and a one-bit-per-cycle
// restoring divider; a single 2*DATA_W negate stage restores the sign.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     abort the operation in flight, no response
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_op[2:0]               RV32M funct3
//   req_a, req_b [DATA_W]     rs1 / rs2, captured at accept
//   resp_valid/resp_ready     response handshake
//   resp_result [DATA_W]      registered result, stable while resp_valid
//   busy                      state != IDLE
module nanorv32_muldiv_seq
    import nanorv32_muldiv_seq_pkg::*;
#(
    parameter int DATA_W     = NANORV32_DATA_W,
    parameter int MUL_UNROLL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              busy
);

    localparam int MUL_N = DATA_W / MUL_UNROLL;
    localparam int CNT_W = $clog2(DATA_W);
    // acc = {hi[DATA_W:0], lo[DATA_W-1:0]}
    //   multiply: hi = running partial sum (+carry), lo = unconsumed multiplier
    //   divide:   hi = partial remainder (DATA_W+1 bits), lo = dividend/quotient
    localparam int ACC_W = 2 * DATA_W + 1;

    muldiv_state_t     state, state_nxt;
    logic [2:0]        op;
    logic              neg;
    logic [DATA_W-1:0] b_mag;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] result;

    // ------------------------------------------------------------------
    // Request decode and operand magnitudes
    // ------------------------------------------------------------------
    muldiv_dec_t       req_dec;
    logic              sign_a, sign_b, req_neg;
    logic [DATA_W-1:0] a_mag_in, b_mag_in;
    logic              accept, div_zero, div_ovf, special;
    logic [DATA_W-1:0] special_result;

    assign req_dec = muldiv_decode(req_op);
    assign sign_a  = req_dec.a_signed & req_a[DATA_W-1];
    assign sign_b  = req_dec.b_signed & req_b[DATA_W-1];
    // Remainder takes the dividend's sign; everything else the product sign
    assign req_neg = req_dec.is_rem ? sign_a : (sign_a ^ sign_b);

    nanorv32_muldiv_absneg #(.WIDTH(DATA_W)) u_abs_a (
        .in  (req_a),
        .neg (sign_a),
        .out (a_mag_in)
    );

    nanorv32_muldiv_absneg #(.WIDTH(DATA_W)) u_abs_b (
        .in  (req_b),
        .neg (sign_b),
        .out (b_mag_in)
    );

    assign accept   = req_valid & (state == NANORV32_MULDIV_ST_IDLE) & ~flush;
    assign div_zero = (req_b == '0);
    // Signed divide of the most negative value by -1 overflows
    assign div_ovf  = req_dec.a_signed & ~req_dec.is_mul &
                      (req_a == {1'b1, {(DATA_W-1){1'b0}}}) & (req_b == '1);
    assign special  = ~req_dec.is_mul & (div_zero | div_ovf);

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = req_dec.is_rem ? req_a : '1;
        else
            special_result = req_dec.is_rem ? '0 : req_a;
    end

    // ------------------------------------------------------------------
    // Multiplier step: MUL_UNROLL add-and-shift stages chained per cycle
    // ------------------------------------------------------------------
    logic [MUL_UNROLL:0][ACC_W-1:0] mul_chain;

    assign mul_chain[0] = acc;

    for (genvar k = 0; k < MUL_UNROLL; k++) begin : g_mul_step
        logic [DATA_W:0] sum;
        // hi carries a zero top bit between steps, so the sum fits DATA_W+1
        assign sum = mul_chain[k][ACC_W-1:DATA_W] +
                     {1'b0, b_mag & {DATA_W{mul_chain[k][0]}}};
        assign mul_chain[k+1] = {1'b0, sum, mul_chain[k][DATA_W-1:1]};
    end

    // ------------------------------------------------------------------
    // Divider step: restoring, one quotient bit per cycle
    // ------------------------------------------------------------------
    logic [DATA_W:0]  rem_shift, rem_diff;
    logic             div_ge;
    logic [ACC_W-1:0] div_next;

    assign rem_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign div_ge    = rem_shift >= {1'b0, b_mag};
    assign rem_diff  = rem_shift - {1'b0, b_mag};
    assign div_next  = {(div_ge ? rem_diff : rem_shift), acc[DATA_W-2:0], div_ge};

    // ------------------------------------------------------------------
    // Sign fixup and result select
    // ------------------------------------------------------------------
    logic                op_is_mul, op_is_rem;
    logic [2*DATA_W-1:0] fix_in, fix_out;
    logic [DATA_W-1:0]   fix_word;

    assign op_is_mul = ~op[2];
    assign op_is_rem = op[2] & op[1];

    // Divide results are zero-extended so the one wide negator serves both;
    // the low word of the negated value is the negated quotient/remainder.
    assign fix_in = op_is_mul ? acc[2*DATA_W-1:0]
                              : {{DATA_W{1'b0}},
                                 (op_is_rem ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0])};

    nanorv32_muldiv_absneg #(.WIDTH(2*DATA_W)) u_fix (
        .in  (fix_in),
        .neg (neg),
        .out (fix_out)
    );

    assign fix_word = (op_is_mul && (op != NANORV32_MULDIV_OP_MUL))
                    ? fix_out[2*DATA_W-1:DATA_W]
                    : fix_out[DATA_W-1:0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= NANORV32_MULDIV_ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NANORV32_MULDIV_ST_IDLE:
                if (accept)
                    state_nxt = special ? NANORV32_MULDIV_ST_DONE : NANORV32_MULDIV_ST_CALC;
            NANORV32_MULDIV_ST_CALC:
                if (cnt == '0) state_nxt = NANORV32_MULDIV_ST_FIX;
            NANORV32_MULDIV_ST_FIX:
                state_nxt = NANORV32_MULDIV_ST_DONE;
            NANORV32_MULDIV_ST_DONE:
                if (resp_ready) state_nxt = NANORV32_MULDIV_ST_IDLE;
            default:
                state_nxt = NANORV32_MULDIV_ST_IDLE;
        endcase
        if (flush) state_nxt = NANORV32_MULDIV_ST_IDLE;
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            NANORV32_MULDIV_ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            NANORV32_MULDIV_ST_DONE: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            neg    <= 1'b0;
            b_mag  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            op    <= req_op;
            neg   <= req_neg;
            b_mag <= b_mag_in;
            // Both engines start with |a| in the low half and a clear upper half
            acc   <= {{(DATA_W+1){1'b0}}, a_mag_in};
            cnt   <= req_dec.is_mul ? CNT_W'(MUL_N - 1) : CNT_W'(DATA_W - 1);
            if (special) result <= special_result;
        end else if (!flush) begin
            if (state == NANORV32_MULDIV_ST_CALC) begin
                acc <= op_is_mul ? mul_chain[MUL_UNROLL] : div_next;
                cnt <= cnt - 1'b1;
            end else if (state == NANORV32_MULDIV_ST_FIX) begin
                result <= fix_word;
            end
        end
    end

    assign resp_result = result;

endmodule
